// File: rtl/bft_pkt_pkg.sv
// ============================================================================
// Module : bft_pkt_pkg
// Brief  : BFT packet field layout, control codes, packetizer FSM states and
//          the data-packet build helper shared by the packetizer files.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bft_pkt_pkg;

  localparam int PKT_W     = 49;
  localparam int PAYLOAD_W = 32;
  localparam int LEAF_W    = 4;
  localparam int PORT_W    = 4;
  localparam int ADDR_W    = 7;

  localparam int VALID_BIT = 48;
  localparam int LEAF_LSB  = 44;
  localparam int PORT_LSB  = 40;
  localparam int ADDR_LSB  = 33;
  localparam int CTRL_BIT  = 32;

  localparam logic CTRL_DATA   = 1'b0;
  localparam logic CTRL_UPDATE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } pkt_state_t;

  function automatic logic [PKT_W-1:0] build_packet(
    input logic [LEAF_W-1:0]    leaf,
    input logic [PORT_W-1:0]    port,
    input logic [ADDR_W-1:0]    addr,
    input logic                 ctrl,
    input logic [PAYLOAD_W-1:0] payload
  );
    return {1'b1, leaf, port, addr, ctrl, payload};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bft_credit_counter.sv
// ============================================================================
// Module : bft_credit_counter
// Brief  : Saturating credit counter; decrement by one and increment by n may
//          occur in the same cycle, result clamps at MAX_COUNT.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bft_credit_counter #(
  parameter int COUNT_BITS = 8,
  parameter int INC_BITS   = 8,
  parameter int MAX_COUNT  = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec,
  input  logic                  inc_en,
  input  logic [INC_BITS-1:0]   inc_n,
  output logic [COUNT_BITS-1:0] count
);

  localparam int SUM_BITS = ((COUNT_BITS > INC_BITS) ? COUNT_BITS : INC_BITS) + 2;
  localparam logic [SUM_BITS-1:0] MAX_SUM = SUM_BITS'(MAX_COUNT);

  logic                  dec_ok;
  logic [SUM_BITS-1:0]   sum;
  logic [COUNT_BITS-1:0] count_next;

  // Never decrement below zero even if a caller forgets to gate on credits.
  assign dec_ok = dec & (count != '0);

  always_comb begin
    sum = SUM_BITS'(count) + (inc_en ? SUM_BITS'(inc_n) : '0) - SUM_BITS'(dec_ok);
    if (sum > MAX_SUM) begin
      count_next = COUNT_BITS'(MAX_COUNT);
    end else begin
      count_next = sum[COUNT_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= COUNT_BITS'(MAX_COUNT);
    end else begin
      count <= count_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bft_stream_packetizer.sv
// ============================================================================
// Module : bft_stream_packetizer
// Brief  : Wraps a 32b user stream into BFT data packets with credit-based flow
//          control and resend hold. Optional counters via BFT_PKT_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bft_stream_packetizer
  import bft_pkt_pkg::*;
#(
  parameter int PACKET_BITS        = 49,
  parameter int PAYLOAD_BITS       = 32,
  parameter int NUM_LEAF_BITS      = 4,
  parameter int NUM_PORT_BITS      = 4,
  parameter int NUM_ADDR_BITS      = 7,
  parameter int NUM_BRAM_ADDR_BITS = 7,
  parameter int SELF_LEAF          = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PAYLOAD_BITS-1:0]   s_tdata,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [NUM_LEAF_BITS-1:0]  cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]  cfg_dest_port,
  output logic [PACKET_BITS-1:0]    dout_bft,
  input  logic [PACKET_BITS-1:0]    din_bft,
  input  logic                      resend,
  output logic [NUM_BRAM_ADDR_BITS:0] credits
`ifdef BFT_PKT_STATS_EN
  ,
  output logic [31:0]               stat_sent,
  output logic [31:0]               stat_resend,
  output logic [31:0]               stat_stall
`endif
);

  localparam int MAX_CREDITS = 1 << NUM_BRAM_ADDR_BITS;
  localparam logic [NUM_LEAF_BITS-1:0] SELF_ID = NUM_LEAF_BITS'(SELF_LEAF);

  pkt_state_t                 state;
  pkt_state_t                 next_state;
  logic [NUM_ADDR_BITS-1:0]   wr_ptr;
  logic [PACKET_BITS-1:0]     dout_next;
  logic                       accept;
  logic                       update;
  logic                       unused_din;

  assign s_tready = (credits != '0) & ~resend & ~reset;
  assign accept   = s_tvalid & s_tready;

  assign update = din_bft[VALID_BIT]
                & (din_bft[CTRL_BIT] == CTRL_UPDATE)
                & (din_bft[LEAF_LSB +: NUM_LEAF_BITS] == SELF_ID);

  // Port/addr and upper payload of incoming updates carry no meaning here.
  assign unused_din = ^{din_bft[LEAF_LSB-1:CTRL_BIT+1], din_bft[PAYLOAD_BITS-1:8]};

  bft_credit_counter #(
    .COUNT_BITS (NUM_BRAM_ADDR_BITS + 1),
    .INC_BITS   (8),
    .MAX_COUNT  (MAX_CREDITS)
  ) u_credits (
    .clk    (clk),
    .reset  (reset),
    .dec    (accept),
    .inc_en (update),
    .inc_n  (din_bft[7:0]),
    .count  (credits)
  );

  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE, ST_SEND, ST_HOLD: begin
        if (resend) begin
          next_state = ST_HOLD;
        end else if (accept) begin
          next_state = ST_SEND;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    dout_next = '0;
    case (next_state)
      ST_HOLD: dout_next = dout_bft;
      ST_SEND: dout_next = build_packet(cfg_dest_leaf, cfg_dest_port, wr_ptr,
                                        CTRL_DATA, s_tdata);
      default: dout_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      dout_bft <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= next_state;
      dout_bft <= dout_next;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

`ifdef BFT_PKT_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_sent   <= '0;
      stat_resend <= '0;
      stat_stall  <= '0;
    end else begin
      if (accept) stat_sent <= stat_sent + 32'd1;
      if (resend) stat_resend <= stat_resend + 32'd1;
      if (s_tvalid && credits == '0) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
